// File: rtl/vid_axis_pkg.sv
// rtl/vid_axis_pkg.sv - shared types and field layout for the native-to-AXI-Stream video path
package vid_axis_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_DE = 2'd1,
        ACTIVE  = 2'd2,
        DROP    = 2'd3
    } n2a_state_t;

    localparam int DSIZE_DEF = 24;
    localparam int FW        = DSIZE_DEF + 2;
    localparam int TUSER_BIT = FW - 1;
    localparam int TLAST_BIT = FW - 2;

    // FIFO word is {tuser, tlast, data}; these track the layout for any pixel width
    function automatic int tuser_idx(input int dsize);
        return dsize + 1;
    endfunction

    function automatic int tlast_idx(input int dsize);
        return dsize;
    endfunction

endpackage

// File: rtl/vdma_sc_fifo.sv
// rtl/vdma_sc_fifo.sv - single-clock first-word-fall-through FIFO with full/empty/count
module vdma_sc_fifo #(
    parameter int W     = 26,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         wr_ok;
    logic         rd_ok;

    // Extra pointer MSB distinguishes full from empty when the index bits match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A write into a full FIFO is fine when the head is leaving in the same cycle
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;

    // Head word is read straight from storage, so it appears the cycle after its write
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array; contents need no reset because empty masks them
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update; natural wrap-around of the AW+1 bit counters
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/native_to_axis.sv
// rtl/native_to_axis.sv - native vsync/hsync/de video to AXI4-Stream video with overflow frame drop
module native_to_axis
    import vid_axis_pkg::*;
#(
    parameter int DSIZE  = DSIZE_DEF,
    parameter int DEPTH  = 16,
    parameter bit VS_POL = 1'b1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [15:0]      vactive,
    input  logic [15:0]      hactive,
    input  logic             vsync,
    input  logic             hsync,
    input  logic             de,
    input  logic [DSIZE-1:0] idata,
    output logic [DSIZE-1:0] axi_tdata,
    output logic             axi_tvalid,
    input  logic             axi_tready,
    output logic             axi_tuser,
    output logic             axi_tlast,
    output logic             overflow,
    output logic             frame_err,
    output logic             frame_done
);

    localparam int W  = DSIZE + 2;
    localparam int UB = tuser_idx(DSIZE);
    localparam int LB = tlast_idx(DSIZE);
    localparam int CW = $clog2(DEPTH) + 1;

    n2a_state_t state, state_nxt;

    logic             vs_lvl, vs_q, vs_edge;
    logic             stg_valid, stg_user, stg_last;
    logic [DSIZE-1:0] stg_data;
    logic [15:0]      pix_cnt, line_cnt, line_total;
    logic             pix_hit;
    logic             stage_en, wr_req, wr_en, wr_last, ovf_hit, chk_en, rd_en;
    logic [W-1:0]     wr_word, rd_word;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             unused_sigs;

    assign unused_sigs = hsync ^ (^fifo_count);

    // Normalise vsync so the active edge is always a rising edge
    assign vs_lvl  = vsync ^ !VS_POL;
    assign vs_edge = vs_lvl && !vs_q;
    assign pix_hit = (hactive != 16'd0) && (pix_cnt == hactive - 16'd1);

    // Registered copy of vsync for edge detection
    always_ff @(posedge clock) begin
        if (rst) vs_q <= 1'b0;
        else     vs_q <= vs_lvl;
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: vsync edges restart the frame, a refused write drops the rest
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_edge) state_nxt = WAIT_DE;
            WAIT_DE: if (de)      state_nxt = ACTIVE;
            ACTIVE:  if (vs_edge) state_nxt = WAIT_DE;
                     else if (ovf_hit) state_nxt = DROP;
            DROP:    if (vs_edge) state_nxt = WAIT_DE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: staging, FIFO write request, overflow detect, line-count check
    always_comb begin
        stage_en = de && ((state == WAIT_DE) || ((state == ACTIVE) && !vs_edge));
        wr_req   = stg_valid && (state == ACTIVE);
        ovf_hit  = wr_req && fifo_full && !rd_en;
        wr_en    = wr_req && !ovf_hit;
        chk_en   = vs_edge && ((state == ACTIVE) || (state == DROP));
    end

    // End of line is known one cycle late: de falling, hactive reached, or a frame edge
    assign wr_last    = stg_last || !de || vs_edge;
    assign wr_word    = {stg_user, wr_last, stg_data};
    assign line_total = line_cnt + {15'd0, wr_en && wr_last};

    // Staging register and per-line pixel counter
    always_ff @(posedge clock) begin
        if (rst) begin
            stg_valid <= 1'b0;
            stg_user  <= 1'b0;
            stg_last  <= 1'b0;
            stg_data  <= '0;
            pix_cnt   <= '0;
        end else if (stage_en) begin
            stg_valid <= 1'b1;
            stg_user  <= (state == WAIT_DE);
            stg_last  <= pix_hit;
            stg_data  <= idata;
            pix_cnt   <= pix_hit ? 16'd0 : pix_cnt + 16'd1;
        end else begin
            stg_valid <= 1'b0;
            stg_last  <= 1'b0;
            pix_cnt   <= '0;
        end
    end

    // Line counter, frame status pulses and sticky overflow
    always_ff @(posedge clock) begin
        if (rst) begin
            line_cnt   <= '0;
            frame_err  <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_err  <= chk_en && (vactive != 16'd0) && (line_total != vactive);
            frame_done <= wr_en && wr_last && (vactive != 16'd0) && ((line_cnt + 16'd1) == vactive);
            overflow   <= overflow || ovf_hit;
            if (vs_edge)               line_cnt <= '0;
            else if (wr_en && wr_last) line_cnt <= line_cnt + 16'd1;
        end
    end

    vdma_sc_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Stream side; fields are forced to 0 when nothing is valid
    assign axi_tvalid = !fifo_empty;
    assign rd_en      = axi_tvalid && axi_tready;
    assign axi_tdata  = fifo_empty ? '0   : rd_word[DSIZE-1:0];
    assign axi_tuser  = fifo_empty ? 1'b0 : rd_word[UB];
    assign axi_tlast  = fifo_empty ? 1'b0 : rd_word[LB];

endmodule

// File: tb/tb_native_to_axis.sv
// tb/tb_native_to_axis.sv - directed self-checking bench for native_to_axis
module tb_native_to_axis;
    import vid_axis_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] vactive, hactive;
    logic        vsync, hsync, de;
    logic [23:0] idata;
    logic [23:0] axi_tdata;
    logic        axi_tvalid, axi_tready, axi_tuser, axi_tlast;
    logic        overflow, frame_err, frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [25:0] beats [512];
    int beat_cnt = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int base, d0, e0;

    native_to_axis #(.DSIZE(24), .DEPTH(16), .VS_POL(1'b1)) dut (
        .clock      (clk),
        .rst        (rst),
        .vactive    (vactive),
        .hactive    (hactive),
        .vsync      (vsync),
        .hsync      (hsync),
        .de         (de),
        .idata      (idata),
        .axi_tdata  (axi_tdata),
        .axi_tvalid (axi_tvalid),
        .axi_tready (axi_tready),
        .axi_tuser  (axi_tuser),
        .axi_tlast  (axi_tlast),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (axi_tvalid && axi_tready) begin
                beats[beat_cnt] = {axi_tuser, axi_tlast, axi_tdata};
                beat_cnt++;
            end
            if (frame_done) done_cnt++;
            if (frame_err)  err_cnt++;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic u, input logic l, input logic [23:0] d);
        chk(tag, 32'(beats[idx]), 32'({u, l, d}));
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        cycle();
        vsync = 1'b0;
        cycle();
    endtask

    task automatic send_run(input int n, input int start);
        for (int i = 0; i < n; i++) begin
            de    = 1'b1;
            idata = 24'(start + i);
            cycle();
        end
        de    = 1'b0;
        idata = '0;
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && beat_cnt < target; i++) cycle();
        chk(tag, 32'(beat_cnt >= target), 32'd1);
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b0; hsync = 1'b0; de = 1'b0; idata = '0;
        axi_tready = 1'b1; vactive = 16'd2; hactive = 16'd4;
        idle(3);
        chk("rst_tvalid", 32'(axi_tvalid), 32'd0);
        chk("rst_tdata",  32'(axi_tdata),  32'd0);
        chk("rst_flags",  32'({axi_tuser, axi_tlast, overflow, frame_err, frame_done}), 32'd0);
        rst = 1'b0;
        idle(2);

        // 1: two 4-pixel lines, no back-pressure
        base = beat_cnt; d0 = done_cnt; e0 = err_cnt;
        vs_pulse();
        send_run(4, 1);
        idle(3);
        send_run(4, 5);
        wait_beats("t1_tmo", base + 8, 40);
        idle(3);
        for (int i = 0; i < 8; i++)
            chk_beat($sformatf("t1_beat%0d", i), base + i, i == 0, (i == 3) || (i == 7), 24'(i + 1));
        chk("t1_done", 32'(done_cnt - d0), 32'd1);
        chk("t1_err",  32'(err_cnt - e0),  32'd0);
        chk("t1_cnt",  32'(beat_cnt - base), 32'd8);

        // 2: same frame (one 8-pixel de run) held off by tready=0 for 20 cycles
        axi_tready = 1'b0;
        base = beat_cnt; e0 = err_cnt;
        vs_pulse();
        send_run(8, 1);
        idle(10);
        chk("t2_ovf",    32'(overflow),   32'd0);
        chk("t2_valid",  32'(axi_tvalid), 32'd1);
        chk("t2_head",   32'({axi_tuser, axi_tlast, axi_tdata}), 32'({1'b1, 1'b0, 24'd1}));
        chk("t2_nobeat", 32'(beat_cnt - base), 32'd0);
        axi_tready = 1'b1;
        wait_beats("t2_tmo", base + 8, 40);
        for (int i = 0; i < 8; i++)
            chk_beat($sformatf("t2_beat%0d", i), base + i, i == 0, (i == 3) || (i == 7), 24'(i + 1));
        chk("t2_err", 32'(err_cnt - e0), 32'd0);

        // 3: 20 pixels into a stalled 16-deep FIFO; pixel 17 overflows
        vactive = 16'd0; hactive = 16'd32; axi_tready = 1'b0;
        base = beat_cnt;
        vs_pulse();
        send_run(20, 101);
        idle(2);
        chk("t3_ovf",   32'(overflow),  32'd1);
        chk("t3_state", 32'(dut.state), 32'(DROP));
        axi_tready = 1'b1;
        idle(25);
        chk("t3_cnt",   32'(beat_cnt - base), 32'd16);
        chk_beat("t3_first", base,      1'b1, 1'b0, 24'd101);
        chk_beat("t3_last",  base + 15, 1'b0, 1'b0, 24'd116);
        hactive = 16'd4;
        base = beat_cnt;
        vs_pulse();
        send_run(4, 201);
        wait_beats("t3b_tmo", base + 4, 30);
        for (int i = 0; i < 4; i++)
            chk_beat($sformatf("t3b_beat%0d", i), base + i, i == 0, i == 3, 24'(201 + i));
        chk("t3_sticky", 32'(overflow), 32'd1);

        // 4: vactive=3 but only two lines -> frame_err at the next vsync edge
        vs_pulse();
        vactive = 16'd3;
        d0 = done_cnt;
        send_run(4, 1);
        idle(2);
        send_run(4, 5);
        idle(6);
        e0 = err_cnt;
        vs_pulse();
        idle(2);
        chk("t4_err",  32'(err_cnt - e0),  32'd1);
        chk("t4_done", 32'(done_cnt - d0), 32'd0);

        // 5: hactive=0, line ends come only from de falling
        vactive = 16'd0; hactive = 16'd0;
        base = beat_cnt;
        vs_pulse();
        send_run(5, 301);
        idle(2);
        send_run(3, 401);
        wait_beats("t5_tmo", base + 8, 30);
        for (int i = 0; i < 5; i++)
            chk_beat($sformatf("t5_a%0d", i), base + i, i == 0, i == 4, 24'(301 + i));
        for (int i = 0; i < 3; i++)
            chk_beat($sformatf("t5_b%0d", i), base + 5 + i, 1'b0, i == 2, 24'(401 + i));

        // 6: reset with six words queued and tvalid high
        hactive = 16'd4; axi_tready = 1'b0;
        vs_pulse();
        send_run(6, 501);
        idle(3);
        chk("t6_pre_valid", 32'(axi_tvalid), 32'd1);
        chk("t6_pre_data",  32'(axi_tdata),  32'd501);
        rst = 1'b1;
        cycle();
        chk("t6_rst_valid", 32'(axi_tvalid), 32'd0);
        chk("t6_rst_data",  32'(axi_tdata),  32'd0);
        chk("t6_rst_flags", 32'({axi_tuser, axi_tlast, overflow, frame_err, frame_done}), 32'd0);
        rst = 1'b0;
        axi_tready = 1'b1; vactive = 16'd1;
        idle(2);
        chk("t6_post_valid", 32'(axi_tvalid), 32'd0);
        base = beat_cnt; d0 = done_cnt;
        vs_pulse();
        send_run(4, 601);
        wait_beats("t6_tmo", base + 4, 30);
        idle(2);
        for (int i = 0; i < 4; i++)
            chk_beat($sformatf("t6_beat%0d", i), base + i, i == 0, i == 3, 24'(601 + i));
        chk("t6_done", 32'(done_cnt - d0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
